// File: rtl/fsd_text_buffer_pkg.sv
// Shared ASCII constants and FSM encoding for the keyboard line buffer.
package fsd_text_buffer_pkg;

  localparam int ASCII_BIT_WIDTH = 8;
  localparam logic [ASCII_BIT_WIDTH-1:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    ST_STATIC = 1'b0,
    ST_SCROLL = 1'b1
  } fsd_tb_state_e;

endpackage

// File: rtl/fsd_text_buffer_tick_divider.sv
// Rate generator: counts 0..DIV-1 and raises tick for one cycle on the last count.
module fsd_text_buffer_tick_divider #(
  parameter int DIV = 250,
  parameter int W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) cnt_d = '0;
  end

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fsd_text_buffer.sv
// Circular line buffer of typed characters with a right-aligned static view and a
// wrapping marquee view; all outputs are registered from next-state values.
module fsd_text_buffer
  import fsd_text_buffer_pkg::*;
#(
  parameter int DIGIT_COUNT          = 4,
  parameter int DEPTH                = 16,
  parameter int DEPTH_BIT_WIDTH      = 4,
  parameter int SCROLL_DIV           = 250,
  parameter int SCROLL_DIV_BIT_WIDTH = 8,
  parameter logic [ASCII_BIT_WIDTH-1:0] BLANK_CHAR = ASCII_SPACE
) (
  input  logic                                   clk_ctrl,
  input  logic                                   reset_n,
  input  logic [ASCII_BIT_WIDTH-1:0]             char_in,
  input  logic                                   push_n,
  input  logic                                   backspace_n,
  input  logic                                   clear_n,
  input  logic                                   scroll_en,
  output logic [DIGIT_COUNT*ASCII_BIT_WIDTH-1:0] chars,
  output logic [DEPTH_BIT_WIDTH:0]               len,
  output logic                                   empty,
  output logic                                   full,
  output logic                                   scrolling
);

  localparam int LW = DEPTH_BIT_WIDTH + 1;
  // Wide enough for offset + DIGIT_COUNT-1 and head + index before wrapping.
  localparam int PW = DEPTH_BIT_WIDTH + 3;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] DC_L    = LW'(DIGIT_COUNT);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] DC_P    = PW'(DIGIT_COUNT);

  logic [ASCII_BIT_WIDTH-1:0] mem_q [DEPTH];
  logic [ASCII_BIT_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH_BIT_WIDTH-1:0] head_q, head_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] offset_q, offset_d;
  fsd_tb_state_e state_q, state_d;
  logic [DIGIT_COUNT*ASCII_BIT_WIDTH-1:0] chars_q, chars_d;
  logic empty_q, full_q;
  logic do_clear, do_bksp, do_push, edit, div_clear, tick;

  function automatic logic [DEPTH_BIT_WIDTH-1:0] wrap_addr(input logic [PW-1:0] a,
                                                           input logic [PW-1:0] b);
    logic [PW-1:0] s;
    s = a + b;
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[DEPTH_BIT_WIDTH-1:0];
  endfunction

  assign do_clear = !clear_n;
  assign do_bksp  = clear_n && !backspace_n;
  assign do_push  = clear_n && backspace_n && !push_n;
  assign edit     = do_clear || do_bksp || do_push;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    len_d  = len_q;
    if (do_clear) begin
      head_d = '0;
      len_d  = '0;
    end else if (do_bksp) begin
      if (len_q != '0) len_d = len_q - 1'b1;
    end else if (do_push) begin
      if (len_q == DEPTH_L) begin
        // Full line: newest wins, oldest slot is reused.
        mem_d[head_q] = char_in;
        head_d        = wrap_addr(PW'(head_q), PW'(1));
      end else begin
        mem_d[wrap_addr(PW'(head_q), PW'(len_q))] = char_in;
        len_d = len_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = '0;
    case (state_q)
      ST_STATIC: begin
        if (scroll_en && len_d > DC_L) state_d = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (!scroll_en || len_d <= DC_L) begin
          state_d = ST_STATIC;
        end else if (!edit) begin
          offset_d = offset_q;
          if (tick) begin
            if (PW'(offset_q) + PW'(1) == PW'(len_q) + DC_P) offset_d = '0;
            else offset_d = offset_q + 1'b1;
          end
        end
      end
      default: state_d = ST_STATIC;
    endcase
  end

  assign div_clear = !(state_q == ST_SCROLL && state_d == ST_SCROLL && !edit);

  always_comb begin
    chars_d = '0;
    for (int j = 0; j < DIGIT_COUNT; j++) begin
      logic [PW-1:0] idx;
      logic [ASCII_BIT_WIDTH-1:0] digit;
      idx   = '0;
      digit = BLANK_CHAR;
      if (state_d == ST_SCROLL) begin
        // Marquee: index into line followed by DIGIT_COUNT blanks, wrapping mod L.
        idx = PW'(offset_d) + PW'(DIGIT_COUNT - 1 - j);
        if (idx >= PW'(len_d) + DC_P) idx = idx - (PW'(len_d) + DC_P);
        if (idx < PW'(len_d)) digit = mem_d[wrap_addr(PW'(head_d), idx)];
      end else if (PW'(j) < PW'(len_d)) begin
        idx   = PW'(len_d) - PW'(j) - PW'(1);
        digit = mem_d[wrap_addr(PW'(head_d), idx)];
      end
      chars_d[j*ASCII_BIT_WIDTH +: ASCII_BIT_WIDTH] = digit;
    end
  end

  fsd_text_buffer_tick_divider #(
    .DIV (SCROLL_DIV),
    .W   (SCROLL_DIV_BIT_WIDTH)
  ) u_tick_divider (
    .clk   (clk_ctrl),
    .rst_n (reset_n),
    .clear (div_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK_CHAR;
      head_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      state_q  <= ST_STATIC;
      chars_q  <= {DIGIT_COUNT{BLANK_CHAR}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      state_q  <= state_d;
      chars_q  <= chars_d;
      empty_q  <= (len_d == '0);
      full_q   <= (len_d == DEPTH_L);
    end
  end

  assign chars     = chars_q;
  assign len       = len_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign scrolling = (state_q == ST_SCROLL);

endmodule
